// File: rtl/obf_key_array_pkg.sv
// Shared types and the per-net obfuscation function for the key array.
package obf_pkg;

    // 2-bit cell mode {k1,k0}
    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_INV  = 2'b10,
        MODE_ONE  = 2'b01,
        MODE_ZERO = 2'b11
    } obf_mode_e;

    // Shadow-key load progress
    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FULL
    } ld_state_e;

    function automatic logic obf_apply(input obf_mode_e mode, input logic b);
        logic r;
        case (mode)
            MODE_PASS: r = b;
            MODE_INV:  r = ~b;
            MODE_ONE:  r = 1'b1;
            MODE_ZERO: r = 1'b0;
            default:   r = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/obf_key_array_if.sv
// Key-delivery bus between the key/test controller (master) and the array (slave).
interface obf_key_if #(
    parameter int N_NETS  = 5,
    parameter int SHIFT_W = 1
);
    localparam int BEATS = 2 * N_NETS / SHIFT_W;
    localparam int CNT_W = $clog2(BEATS + 1);

    logic               key_valid;
    logic               key_ready;
    logic [SHIFT_W-1:0] key_data;
    logic               key_last;
    logic               key_commit;
    logic               key_clear;
    logic               armed;
    logic               key_err;
    logic [CNT_W-1:0]   beat_cnt;

    modport master (
        output key_valid, key_data, key_last, key_commit, key_clear,
        input  key_ready, armed, key_err, beat_cnt
    );

    modport slave (
        input  key_valid, key_data, key_last, key_commit, key_clear,
        output key_ready, armed, key_err, beat_cnt
    );

endinterface

// File: rtl/obf_key_array_cell.sv
// One obfuscation cell: 4-way select of net, ~net, 1 or 0 by the 2-bit mode.
module obf_cell
    import obf_pkg::*;
(
    input  logic [1:0] mode,
    input  logic       net_in,
    output logic       net_out
);

    assign net_out = obf_apply(obf_mode_e'(mode), net_in);

endmodule

// File: rtl/obf_key_array.sv
// Key-controlled obfuscation array: serial shadow-key load, atomic commit,
// locked (RST_MODE) behaviour until a complete key is committed.
// 2*N_NETS must be a multiple of SHIFT_W.
module obf_key_array
    import obf_pkg::*;
#(
    parameter int         N_NETS   = 5,
    parameter int         SHIFT_W  = 1,
    parameter logic [1:0] RST_MODE = 2'b11,
    parameter bit         REG_OUT  = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_NETS-1:0] net_in,
    output logic [N_NETS-1:0] net_out,
    obf_key_if.slave          key
);

    localparam int KEY_W = 2 * N_NETS;
    localparam int BEATS = KEY_W / SHIFT_W;
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam logic [KEY_W-1:0] RST_KEY = {N_NETS{RST_MODE}};

    ld_state_e          state_q, state_d;
    logic [KEY_W-1:0]   shadow_q, shadow_d;
    logic [KEY_W-1:0]   active_q, active_d;
    logic               armed_q, armed_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [KEY_W+SHIFT_W-1:0] shift_cat;
    logic [KEY_W-1:0]         shadow_shift;
    logic                     beat_acc;
    logic                     last_beat;
    logic [N_NETS-1:0]        net_mix;

    assign key.key_ready = (state_q != FULL);
    assign key.armed     = armed_q;
    assign key.key_err   = err_q;
    assign key.beat_cnt  = cnt_q;

    // New beat enters at the top so the first beat ends up in bit 0 (cell 0 k0)
    assign shift_cat    = {key.key_data, shadow_q};
    assign shadow_shift = shift_cat[KEY_W+SHIFT_W-1:SHIFT_W];
    assign beat_acc     = key.key_valid & key.key_ready;
    assign last_beat    = (cnt_q == CNT_W'(BEATS - 1));

    // Load FSM next-state: clear overrides everything, commit only honoured in FULL
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        active_d = active_q;
        armed_d  = armed_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        if (key.key_clear) begin
            state_d  = IDLE;
            shadow_d = '0;
            active_d = RST_KEY;
            armed_d  = 1'b0;
            err_d    = 1'b0;
            cnt_d    = '0;
        end else if (state_q == FULL) begin
            if (key.key_commit) begin
                active_d = shadow_q;
                armed_d  = 1'b1;
                shadow_d = '0;
                cnt_d    = '0;
                state_d  = IDLE;
            end
        end else begin
            if (key.key_commit) err_d = 1'b1;
            if (beat_acc) begin
                if (key.key_last != last_beat) begin
                    // framing error: early last, or missing last on the final beat
                    err_d    = 1'b1;
                    shadow_d = '0;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end else if (last_beat) begin
                    shadow_d = shadow_shift;
                    cnt_d    = CNT_W'(BEATS);
                    state_d  = FULL;
                end else begin
                    shadow_d = shadow_shift;
                    cnt_d    = cnt_q + CNT_W'(1);
                    state_d  = LOAD;
                end
            end
        end
    end

    // Key state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            active_q <= RST_KEY;
            armed_q  <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            armed_q  <= armed_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    for (genvar i = 0; i < N_NETS; i++) begin : g_cell
        obf_cell u_cell (
            .mode    (active_q[2*i+1:2*i]),
            .net_in  (net_in[i]),
            .net_out (net_mix[i])
        );
    end

    if (REG_OUT) begin : g_reg
        logic [N_NETS-1:0] out_q;
        // Optional output retiming stage
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) out_q <= '0;
            else        out_q <= net_mix;
        end
        assign net_out = out_q;
    end else begin : g_comb
        assign net_out = net_mix;
    end

endmodule
